// File: rtl/ppa_sub_pipe.sv
// ppa_sub_pipe: 3-stage valid/ready 16-bit subtractor (A-B-BI) on a Sklansky prefix carry network; OV port enabled by PPA_SUB_PIPE_OVF_EN
module ppa_sub_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bi,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] d,
  output logic        bo
`ifdef PPA_SUB_PIPE_OVF_EN
  ,
  output logic        ov
`endif
);
  function automatic logic [31:0] lvl(input logic [15:0] g, input logic [15:0] p, input int k);
    logic [15:0] go, po;
    logic [3:0] j;
    go = g;
    po = p;
    for (int i = 0; i < 16; i++) begin
      j = 4'(((i >> k) << k) - 1);
      if (i[k]) begin
        go[i] = g[i] | (p[i] & g[j]);
        po[i] = p[i] & p[j];
      end
    end
    return {po, go};
  endfunction
  logic v1, v2, v3, ld1, ld2, ld3;
  logic [15:0] p1, g1, s1, p2, g2, s2, g0, dn;
  logic c1, c2;
  logic [31:0] pg1, pg2, pg3, pg4;
  logic unused_p;
  assign ld3 = ~v3 | out_ready;
  assign ld2 = ~v2 | ld3;
  assign ld1 = ~v1 | ld2;
  assign in_ready = ld1;
  assign out_valid = v3;
  // carry-in (~bi) is folded into bit 0 generate so the prefix network yields all carries
  assign g0 = {g1[15:1], g1[0] | (p1[0] & c1)};
  assign pg1 = lvl(g0, p1, 0);
  assign pg2 = lvl(pg1[15:0], pg1[31:16], 1);
  assign pg3 = lvl(g2, p2, 2);
  assign pg4 = lvl(pg3[15:0], pg3[31:16], 3);
  assign dn = s2 ^ {pg4[14:0], c2};
  assign unused_p = ^pg4[31:16];
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
    end
  end
  always_ff @(posedge clk) begin
    if (ld1) begin
      p1 <= a | ~b;
      g1 <= a & ~b;
      s1 <= a ^ ~b;
      c1 <= ~bi;
    end
    if (ld2) begin
      p2 <= pg2[31:16];
      g2 <= pg2[15:0];
      s2 <= s1;
      c2 <= c1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      d  <= '0;
      bo <= 1'b0;
    end else if (ld3 & v2) begin
      d  <= dn;
      bo <= ~pg4[15];
    end
  end
`ifdef PPA_SUB_PIPE_OVF_EN
  logic a1, b1, a2, b2;
  always_ff @(posedge clk) begin
    if (ld1) begin
      a1 <= a[15];
      b1 <= b[15];
    end
    if (ld2) begin
      a2 <= a1;
      b2 <= b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) ov <= 1'b0;
    else if (ld3 & v2) ov <= (a2 != b2) & (dn[15] != a2);
  end
`endif
endmodule

// File: tb/tb_ppa_sub_pipe.sv
// tb_ppa_sub_pipe: directed bench for ppa_sub_pipe (latency, borrow corners, stall/backpressure, reset flush, OV when PPA_SUB_PIPE_OVF_EN)
module tb_ppa_sub_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, bi, out_valid, out_ready, bo;
  logic [15:0] a, b, d, dh;
`ifdef PPA_SUB_PIPE_OVF_EN
  logic ov;
`endif
  logic [17:0] q[$];
  logic [17:0] e;
  int checks = 0, errors = 0;

  ppa_sub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bi(bi), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bo(bo)
`ifdef PPA_SUB_PIPE_OVF_EN
    , .ov(ov)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] ref_model(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] r;
    logic o;
    r = {1'b0, x} - {1'b0, y} - 17'(c);
    o = (x[15] != y[15]) & (r[15] != x[15]);
    return {o, r[16], r[15:0]};
  endfunction

  // scoreboard: push on accept, pop and compare on output handshake
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (out_valid && out_ready) begin
        chk("out_pending", 32'(q.size() != 0), 32'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("out_d", 32'(d), 32'(e[15:0]));
          chk("out_bo", 32'(bo), 32'(e[16]));
`ifdef PPA_SUB_PIPE_OVF_EN
          chk("out_ov", 32'(ov), 32'(e[17]));
`endif
        end
      end
      if (in_valid && in_ready) q.push_back(ref_model(a, b, bi));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c);
    int n = 0;
    logic acc;
    a = x;
    b = y;
    bi = c;
    in_valid = 1'b1;
    do begin
      #1;
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    chk("send_timeout", 32'(acc), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic one(input logic [15:0] x, input logic [15:0] y, input logic c,
                     input logic [15:0] ed, input logic ebo, input logic eov);
    out_ready = 1'b1;
    send(x, y, c);
    chk("lat_e0", 32'(out_valid), 32'(0));
    tick();
    chk("lat_e1", 32'(out_valid), 32'(0));
    tick();
    chk("lat_e2", 32'(out_valid), 32'(1));
    chk("one_d", 32'(d), 32'(ed));
    chk("one_bo", 32'(bo), 32'(ebo));
`ifdef PPA_SUB_PIPE_OVF_EN
    chk("one_ov", 32'(ov), 32'(eov));
`else
    if (eov) chk("one_ov_unused", 32'(eov), 32'(eov & ~ebo | ebo & eov));
`endif
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    a = 16'h0001;
    b = 16'h0002;
    bi = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_d", 32'(d), 32'(0));
    chk("rst_bo", 32'(bo), 32'(0));
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    tick();
    one(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);
    one(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    one(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    one(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    one(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    one(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    one(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    // back-to-back stream, then a 5-cycle stall with the pipe full
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
    out_ready = 1'b0;
    in_valid = 1'b1;
    #1;
    dh = d;
    for (int k = 0; k < 5; k++) begin
      chk("stall_in_ready", 32'(in_ready), 32'(0));
      chk("stall_out_valid", 32'(out_valid), 32'(1));
      chk("stall_d", 32'(d), 32'(dh));
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("full_pass_in_ready", 32'(in_ready), 32'(1));
    send(16'($urandom), 16'($urandom), 1'($urandom));
    chk("full_pass_out_valid", 32'(out_valid), 32'(1));
    #1;
    chk("full_pass_in_ready2", 32'(in_ready), 32'(1));
    for (int i = 0; i < 49; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
    repeat (5) tick();
    chk("stream_drain", 32'(q.size()), 32'(0));
    // reset with two beats in flight
    one(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);
    send(16'h4444, 16'h1111, 1'b0);
    send(16'h5555, 16'h2222, 1'b1);
    rst = 1'b1;
    in_valid = 1'b1;
    a = 16'h9999;
    tick();
    chk("flush_out_valid", 32'(out_valid), 32'(0));
    chk("flush_d", 32'(d), 32'(0));
    chk("flush_bo", 32'(bo), 32'(0));
    rst = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("no_stale", 32'(out_valid), 32'(0));
      tick();
    end
    chk("final_drain", 32'(q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ppa_sub_pipe.md
PPA_SUB_PIPE -- requirements
Module: ppa_sub_pipe

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 IN_VALID  input  1  operand beat presented.
REQ-005 IN_READY  output  1  block accepts beat this cycle.
REQ-006 A  input  16  minuend, unsigned.
REQ-007 B  input  16  subtrahend, unsigned.
REQ-008 BI  input  1  borrow-in.
REQ-009 OUT_VALID  output  1  result beat presented.
REQ-010 OUT_READY  input  1  downstream accepts result.
REQ-011 D  output  16  difference.
REQ-012 BO  output  1  borrow-out.
REQ-013 OV  output  1  signed overflow; present only when PPA_SUB_PIPE_OVF_EN is defined.

Function
REQ-014 SHALL compute D = (A - B - BI) mod 2^16 and BO = 1 iff A < B + BI (unsigned), per accepted beat.
REQ-015 SHALL implement the subtraction as A + ~B + ~BI using a 16-bit Sklansky prefix carry network of 4 levels, with p = A|~B, g = A&~B, and a sum term of A^~B.
REQ-016 SHALL have 3 pipeline stages. Stage 1 registers p/g/sum terms, carry-in and operand MSBs. Stage 2 registers the prefix results after levels 1-2. Stage 3 registers the prefix results after levels 3-4, plus D/BO/OV.
REQ-017 Latency SHALL be exactly 3 cycles from the accepting edge to OUT_VALID=1 when OUT_READY is held 1.
REQ-018 Each stage SHALL have a valid bit. A stage SHALL load when it is empty or when its contents advance in the same cycle.
REQ-019 The output stage SHALL advance on OUT_VALID & OUT_READY. IN_READY = ~v1 | advance1, computed combinationally from the valid bits and OUT_READY.
REQ-020 A beat SHALL be accepted on IN_VALID & IN_READY. Inputs sampled while IN_READY=0 SHALL be ignored.
REQ-021 Throughput SHALL be 1 beat/cycle with no bubbles while OUT_READY=1.
REQ-022 While OUT_VALID=1 & OUT_READY=0, D/BO/OV SHALL hold stable. Up to 3 beats SHALL be held, and none SHALL be lost or duplicated.
REQ-023 When all 3 stages are full and OUT_READY=0, IN_READY SHALL be 0.
REQ-024 A simultaneous accept and output handshake on a full pipe SHALL shift all stages by one beat in that cycle.
REQ-025 Results SHALL emerge in acceptance order.
REQ-026 OUT_VALID SHALL never depend combinationally on IN_VALID.

Reset
REQ-027 On RST=1 at a clock edge, all valid bits, D, BO and OV SHALL become 0.
REQ-028 IN_READY SHALL be 1 in the first cycle after reset deassertion.
REQ-029 Reset mid-operation SHALL discard all in-flight beats. Inputs presented in the same cycle as RST=1 SHALL NOT be accepted.
REQ-030 Datapath registers other than the outputs MAY remain unreset, provided their valid bits are cleared.

Configuration
REQ-031 With PPA_SUB_PIPE_OVF_EN defined, port OV SHALL exist and equal (A[15]!=B[15]) & (D[15]!=A[15]) for the same beat. It SHALL be aligned with D.
REQ-032 Without PPA_SUB_PIPE_OVF_EN, port OV and its pipeline flops SHALL be absent. All other behaviour SHALL be unchanged.

Verification
REQ-033 A=0x1234, B=0x0034, BI=0, OUT_READY=1 -> exactly 3 cycles later OUT_VALID=1, D=0x1200, BO=0.
REQ-034 A=0x0000, B=0x0001, BI=0 -> D=0xFFFF, BO=1. A=0x0000, B=0x0000, BI=1 -> D=0xFFFF, BO=1. A=0xFFFF, B=0xFFFF, BI=1 -> D=0xFFFF, BO=1.
REQ-035 Stream 100 random beats back-to-back, then hold OUT_READY=0 for 5 cycles mid-stream -> IN_READY=0 after 3 beats are held, D stable, and output order and values match the reference model.
REQ-036 Full pipe with IN_VALID=1 and OUT_READY=1 in the same cycle -> one beat in and one beat out, IN_READY stays 1.
REQ-037 Assert RST with 2 beats in flight -> next cycle OUT_VALID=0, D=0, BO=0, and no stale result ever appears.
REQ-038 With PPA_SUB_PIPE_OVF_EN defined, A=0x8000, B=0x0001 -> OV=1, D=0x7FFF. A=0x7FFF, B=0xFFFF -> OV=1, D=0x8000. A=0x0005, B=0x0003 -> OV=0.
